// File: rtl/gpio_in_cond.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_in_cond
//  Description : Per-pin GPIO input conditioner. Two-flop synchroniser,
//                optional prescaled debounce, rise/fall edge detection into
//                sticky pending bits, and a masked registered interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_cond #(
  parameter int GPIO_NUM  = 16,
  parameter int DEB_CNT_W = 8,
  parameter int PSC_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [GPIO_NUM-1:0]  pad_in_i,
  input  logic [PSC_W-1:0]     psc_div_i,
  input  logic [DEB_CNT_W-1:0] deb_thr_i,
  input  logic [GPIO_NUM-1:0]  deb_en_i,
  input  logic [GPIO_NUM-1:0]  irq_rise_en_i,
  input  logic [GPIO_NUM-1:0]  irq_fall_en_i,
  input  logic [GPIO_NUM-1:0]  irq_mask_i,
  input  logic [GPIO_NUM-1:0]  irq_clr_i,
  output logic [GPIO_NUM-1:0]  gpio_in_o,
  output logic [GPIO_NUM-1:0]  irq_pend_o,
  output logic                 irq_o
);

  // Warm-up length: covers the two synchroniser stages plus one load cycle.
  localparam logic [1:0]           c_WARM_INIT = 2'd3;
  localparam logic [1:0]           c_WARM_ONE  = 2'd1;
  localparam logic [PSC_W-1:0]     c_PSC_ONE   = PSC_W'(1);
  localparam logic [DEB_CNT_W:0]   c_CNT_ONE   = (DEB_CNT_W + 1)'(1);
  localparam logic [DEB_CNT_W-1:0] c_CNT_MAX   = '1;

  logic [GPIO_NUM-1:0] r_sync1;
  logic [GPIO_NUM-1:0] r_sync2;
  logic [1:0]          r_warm;
  logic                w_warm_active;
  logic [PSC_W-1:0]    r_psc;
  logic                w_tick;
  logic [DEB_CNT_W:0]  w_thr;
  logic [GPIO_NUM-1:0] r_level;
  logic [GPIO_NUM-1:0] w_level_nxt;
  logic [GPIO_NUM-1:0] w_rise;
  logic [GPIO_NUM-1:0] w_fall;
  logic [GPIO_NUM-1:0] w_pend_nxt;
  logic [GPIO_NUM-1:0] r_pend;
  logic                r_irq;

  // Two-flop synchroniser for the asynchronous pad levels.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pad_in_i;
      r_sync2 <= r_sync1;
    end
  end

  // Warm-up counter: lets the conditioned level track the pins after reset
  // without ever reporting the reset-release transition as an edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_warm <= c_WARM_INIT;
    end else if (w_warm_active) begin
      r_warm <= r_warm - c_WARM_ONE;
    end
  end

  assign w_warm_active = (r_warm != 2'd0);

  // Debounce prescaler. A count above a freshly lowered divider wraps to 0
  // without producing a tick, since the equality compare never fires.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_psc <= '0;
    end else if (r_psc >= psc_div_i) begin
      r_psc <= '0;
    end else begin
      r_psc <= r_psc + c_PSC_ONE;
    end
  end

  assign w_tick = (r_psc == psc_div_i);

  // Effective threshold at one extra bit so counter+1 never overflows the
  // compare; a programmed zero behaves like one.
  assign w_thr = (deb_thr_i == '0) ? c_CNT_ONE : {1'b0, deb_thr_i};

  for (genvar n = 0; n < GPIO_NUM; n++) begin : g_pin
    logic [DEB_CNT_W-1:0] r_cnt;
    logic [DEB_CNT_W-1:0] w_cnt_nxt;
    logic [DEB_CNT_W:0]   w_cnt_inc;
    logic                 w_lvl_nxt;

    assign w_cnt_inc = {1'b0, r_cnt} + c_CNT_ONE;

    // Per-pin debounce: commit the synchronised level once it has differed
    // from the current output for the threshold number of ticks.
    always_comb begin
      w_lvl_nxt = r_level[n];
      w_cnt_nxt = r_cnt;
      if (w_warm_active || !deb_en_i[n]) begin
        w_lvl_nxt = r_sync2[n];
        w_cnt_nxt = '0;
      end else if (r_sync2[n] == r_level[n]) begin
        w_cnt_nxt = '0;
      end else if (w_tick) begin
        if (w_cnt_inc >= w_thr) begin
          w_lvl_nxt = r_sync2[n];
          w_cnt_nxt = '0;
        end else if (r_cnt != c_CNT_MAX) begin
          w_cnt_nxt = w_cnt_inc[DEB_CNT_W-1:0];
        end
      end
    end

    // Per-pin debounce counter register.
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end

    assign w_level_nxt[n] = w_lvl_nxt;
  end

  // Edges are taken from the conditioned level, and are ignored while the
  // warm-up counter is still running.
  assign w_rise = ~r_level &  w_level_nxt & {GPIO_NUM{~w_warm_active}};
  assign w_fall =  r_level & ~w_level_nxt & {GPIO_NUM{~w_warm_active}};

  // A new edge overrides a clear strobe arriving in the same cycle.
  assign w_pend_nxt = (r_pend & ~irq_clr_i)
                    | (w_rise & irq_rise_en_i)
                    | (w_fall & irq_fall_en_i);

  // Conditioned level and sticky pending bits.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_level <= '0;
      r_pend  <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Registered interrupt request from the currently held pending bits.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_pend & irq_mask_i);
    end
  end

  assign gpio_in_o  = r_level;
  assign irq_pend_o = r_pend;
  assign irq_o      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_in_cond
//  Description : Scoreboard bench for gpio_in_cond. Stimulus pushes the
//                expected output value for a given cycle; a monitor pops and
//                compares when that cycle's outputs are presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_in_cond;

  localparam int K_GPIO = 0;
  localparam int K_PEND = 1;
  localparam int K_IRQ  = 2;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] pad     = '0;
  logic [15:0] psc_div = 16'd3;
  logic [7:0]  deb_thr = 8'd4;
  logic [15:0] deb_en  = '0;
  logic [15:0] rise_en = '0;
  logic [15:0] fall_en = '0;
  logic [15:0] mask    = '0;
  logic [15:0] clr     = '0;
  logic [15:0] gpio_in;
  logic [15:0] pend;
  logic        irq;

  always #5 clk = ~clk;

  gpio_in_cond #(.GPIO_NUM(16), .DEB_CNT_W(8), .PSC_W(16)) u_dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .pad_in_i      (pad),
    .psc_div_i     (psc_div),
    .deb_thr_i     (deb_thr),
    .deb_en_i      (deb_en),
    .irq_rise_en_i (rise_en),
    .irq_fall_en_i (fall_en),
    .irq_mask_i    (mask),
    .irq_clr_i     (clr),
    .gpio_in_o     (gpio_in),
    .irq_pend_o    (pend),
    .irq_o         (irq)
  );

  int cyc      = 0;
  int n_checks = 0;
  int n_err    = 0;
  int rel      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int          q_due[$];
  int          q_kind[$];
  logic [15:0] q_mask[$];
  logic [15:0] q_val[$];
  string       q_name[$];

  task automatic push_exp(input int due, input int kind, input logic [15:0] m,
                          input logic [15:0] v, input string name);
    q_due.push_back(due);
    q_kind.push_back(kind);
    q_mask.push_back(m);
    q_val.push_back(v);
    q_name.push_back(name);
  endtask

  task automatic drop(input int i);
    q_due.delete(i);
    q_kind.delete(i);
    q_mask.delete(i);
    q_val.delete(i);
    q_name.delete(i);
  endtask

  // Monitor: after each edge, compare every entry due on this cycle.
  always @(posedge clk) begin : mon
    logic [15:0] act;
    #2;
    for (int i = q_due.size() - 1; i >= 0; i--) begin
      if (q_due[i] <= cyc) begin
        case (q_kind[i])
          K_GPIO:  act = gpio_in;
          K_PEND:  act = pend;
          default: act = {15'd0, irq};
        endcase
        n_checks++;
        if (q_due[i] < cyc) begin
          n_err++;
          $display("FAIL %s: due cycle %0d passed unsampled (now %0d)", q_name[i], q_due[i], cyc);
        end else if ((act & q_mask[i]) !== (q_val[i] & q_mask[i])) begin
          n_err++;
          $display("FAIL %s @cycle %0d: got %h required %h (mask %h)",
                   q_name[i], cyc, act & q_mask[i], q_val[i] & q_mask[i], q_mask[i]);
        end
        drop(i);
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset for n edges; all outputs must read zero after the last reset edge.
  task automatic do_reset(input logic [15:0] pads, input int n);
    pad   = pads;
    rst_n = 1'b0;
    push_exp(cyc + n, K_GPIO, 16'hFFFF, 16'h0000, "rst_gpio");
    push_exp(cyc + n, K_PEND, 16'hFFFF, 16'h0000, "rst_pend");
    push_exp(cyc + n, K_IRQ,  16'h0001, 16'h0000, "rst_irq");
    wait_n(n);
    rst_n = 1'b1;
    rel   = cyc;
  endtask

  // Position so the first edge acting on a new pad level is a tick edge.
  task automatic align4();
    while (((cyc + 3 - rel) % 4) != 0) wait_n(1);
  endtask

  // Warm-up expectations after a reset with pins held at 'pads'.
  task automatic warm_checks(input logic [15:0] pads);
    push_exp(rel + 2, K_GPIO, 16'hFFFF, 16'h0000, "warm_gpio_early");
    push_exp(rel + 3, K_GPIO, 16'hFFFF, pads,     "warm_gpio_loaded");
    for (int d = 1; d <= 8; d++) begin
      push_exp(rel + d, K_PEND, 16'hFFFF, 16'h0000, "warm_pend");
      push_exp(rel + d, K_IRQ,  16'h0001, 16'h0000, "warm_irq");
    end
  endtask

  initial begin
    int k;
    int g;
    @(negedge clk);

    // Reset with all pins high and rising interrupts enabled.
    rise_en = 16'hFFFF; mask = 16'hFFFF; deb_en = 16'h0000;
    do_reset(16'hFFFF, 2);
    warm_checks(16'hFFFF);
    wait_n(9);

    // Debounce off: pin 3 latency, pending, irq, then clear.
    rise_en = 16'h0008; mask = 16'h0008; fall_en = 16'h0000;
    do_reset(16'h0000, 2);
    wait_n(6);
    pad = 16'h0008; k = cyc;
    push_exp(k + 2, K_GPIO, 16'h0008, 16'h0000, "nodeb_gpio_e1");
    push_exp(k + 3, K_GPIO, 16'hFFFF, 16'h0008, "nodeb_gpio_e2");
    push_exp(k + 3, K_PEND, 16'hFFFF, 16'h0008, "nodeb_pend_e2");
    push_exp(k + 3, K_IRQ,  16'h0001, 16'h0000, "nodeb_irq_e2");
    push_exp(k + 4, K_IRQ,  16'h0001, 16'h0001, "nodeb_irq_e3");
    wait_n(5);
    clr = 16'h0008; k = cyc;
    push_exp(k + 1, K_PEND, 16'hFFFF, 16'h0000, "clr_pend");
    push_exp(k + 1, K_IRQ,  16'h0001, 16'h0001, "clr_irq_hold");
    push_exp(k + 2, K_IRQ,  16'h0001, 16'h0000, "clr_irq_low");
    wait_n(1); clr = 16'h0000;
    wait_n(4);

    // Debounce on pin 5: psc_div=3, thr=4, tick-aligned step then a glitch.
    rise_en = 16'h0020; fall_en = 16'h0020; mask = 16'h0000; deb_en = 16'h0020;
    psc_div = 16'd3; deb_thr = 8'd4;
    do_reset(16'h0000, 2);
    wait_n(6);
    align4();
    pad = 16'h0020; k = cyc;
    push_exp(k + 10, K_GPIO, 16'h0020, 16'h0000, "deb_mid");
    push_exp(k + 14, K_GPIO, 16'h0020, 16'h0000, "deb_before_commit");
    push_exp(k + 15, K_GPIO, 16'hFFFF, 16'h0020, "deb_commit");
    push_exp(k + 15, K_PEND, 16'hFFFF, 16'h0020, "deb_pend");
    wait_n(18);
    clr = 16'h0020;
    push_exp(cyc + 1, K_PEND, 16'hFFFF, 16'h0000, "deb_clr");
    wait_n(1); clr = 16'h0000;
    wait_n(2);
    pad = 16'h0000; g = cyc;
    push_exp(g + 8,  K_GPIO, 16'hFFFF, 16'h0020, "glitch_gpio_in");
    push_exp(g + 13, K_GPIO, 16'hFFFF, 16'h0020, "glitch_gpio_end");
    push_exp(g + 25, K_GPIO, 16'hFFFF, 16'h0020, "glitch_gpio_after");
    push_exp(g + 25, K_PEND, 16'hFFFF, 16'h0000, "glitch_pend");
    wait_n(10);
    pad = 16'h0020;
    wait_n(17);

    // Falling edge on pin 12 while masked, then unmask.
    rise_en = 16'h0000; fall_en = 16'h1000; mask = 16'h0000; deb_en = 16'h0000;
    do_reset(16'h1000, 2);
    wait_n(6);
    push_exp(cyc + 1, K_GPIO, 16'hFFFF, 16'h1000, "fall_init");
    pad = 16'h0000; k = cyc;
    push_exp(k + 3, K_GPIO, 16'hFFFF, 16'h0000, "fall_gpio");
    push_exp(k + 3, K_PEND, 16'hFFFF, 16'h1000, "fall_pend");
    push_exp(k + 4, K_IRQ,  16'h0001, 16'h0000, "fall_masked_irq");
    push_exp(k + 6, K_IRQ,  16'h0001, 16'h0000, "fall_masked_irq2");
    wait_n(6);
    mask = 16'h1000; k = cyc;
    push_exp(k + 1, K_IRQ,  16'h0001, 16'h0001, "unmask_irq");
    push_exp(k + 1, K_PEND, 16'hFFFF, 16'h1000, "unmask_pend_kept");
    wait_n(3);

    // Set/clear collision on pin 0.
    rise_en = 16'h0001; fall_en = 16'h0000; mask = 16'h0001; deb_en = 16'h0000;
    do_reset(16'h0000, 2);
    wait_n(6);
    pad = 16'h0001; k = cyc;
    push_exp(k + 3, K_GPIO, 16'h0001, 16'h0001, "coll_gpio");
    push_exp(k + 3, K_PEND, 16'hFFFF, 16'h0001, "coll_pend");
    push_exp(k + 4, K_PEND, 16'hFFFF, 16'h0001, "coll_pend_hold");
    push_exp(k + 4, K_IRQ,  16'h0001, 16'h0001, "coll_irq");
    wait_n(2);
    clr = 16'h0001;
    wait_n(1); clr = 16'h0000;
    wait_n(3);

    // Reset while pin 5's debounce count is at 2 of 4.
    rise_en = 16'h0020; fall_en = 16'h0020; mask = 16'h0020; deb_en = 16'h0020;
    do_reset(16'h0000, 2);
    wait_n(6);
    align4();
    pad = 16'h0020; k = cyc;
    push_exp(k + 8, K_GPIO, 16'h0020, 16'h0000, "midcnt_gpio");
    wait_n(8);
    do_reset(16'h0020, 1);
    warm_checks(16'h0020);
    wait_n(9);
    align4();
    pad = 16'h0000; k = cyc;
    push_exp(k + 14, K_GPIO, 16'h0020, 16'h0020, "restart_before_commit");
    push_exp(k + 15, K_GPIO, 16'h0020, 16'h0000, "restart_commit");
    push_exp(k + 15, K_PEND, 16'hFFFF, 16'h0020, "restart_fall_pend");
    push_exp(k + 16, K_IRQ,  16'h0001, 16'h0001, "restart_irq");
    wait_n(20);

    // Anything still queued was never compared.
    while (q_due.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: due cycle %0d never reached", q_name[0], q_due[0]);
      drop(0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/gpio_in_cond.md
# gpio_in_cond

Per-pin input conditioner between the GPIO pad receivers (`p2c`) and the SoC GPIO input bus. It provides:
- a 2-flop synchroniser per pin;
- an optional prescaled debounce filter per pin;
- rising/falling edge detection with sticky per-pin interrupt pending bits;
- a masked, registered interrupt request.

The conditioned level feeds the SoC core's `gpio_in_i`.

## Interface
- `GPIO_NUM`, 16, number of pins.
- `DEB_CNT_W`, 8, debounce counter / threshold width.
- `PSC_W`, 16, prescaler width.

- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  reset; one clock; synchronous, active-low.
- `pad_in_i`  in  GPIO_NUM  raw asynchronous pad levels.
- `psc_div_i`  in  PSC_W  debounce tick period minus 1.
- `deb_thr_i`  in  DEB_CNT_W  ticks of stability required; 0 is treated as 1.
- `deb_en_i`  in  GPIO_NUM  per-pin debounce enable.
- `irq_rise_en_i`  in  GPIO_NUM  pending on rising edge.
- `irq_fall_en_i`  in  GPIO_NUM  pending on falling edge.
- `irq_mask_i`  in  GPIO_NUM  1 = pin contributes to `irq_o`.
- `irq_clr_i`  in  GPIO_NUM  single-cycle clear strobe, per pin.
- `gpio_in_o`  out  GPIO_NUM  conditioned level to the core.
- `irq_pend_o`  out  GPIO_NUM  sticky pending bits.
- `irq_o`  out  1  registered OR of `irq_pend_o & irq_mask_i`.

## Operation
- **Reset (`rst_n_i`=0 at a clock edge)**
  - Clears: sync stages, `gpio_in_o`, `irq_pend_o`, `irq_o`, all debounce counters, prescaler.
  - Loads the warm-up counter with 3.
  - Reset asserted mid-debounce or with a pending bit set discards that state completely.
- **Warm-up**
  - While warm-up counter ≠ 0 it decrements each cycle.
  - During warm-up `gpio_in_o` loads the sync-stage-2 value every cycle, debounce is bypassed, and no edges are detected.
  - Purpose: pins that are high at reset release do not raise spurious rising-edge interrupts.
- **Prescaler**
  - Counter runs 0..`psc_div_i`, then wraps to 0.
  - `tick` is asserted in the cycle the counter equals `psc_div_i`; `psc_div_i`=0 gives a tick every cycle.
  - If `psc_div_i` is lowered below the current count, the counter wraps to 0 on the next cycle with no tick.
- **Debounce, per pin, after warm-up**
  - `s` = sync-stage-2 output.
  - `deb_en_i[n]`=0: `gpio_in_o[n]` <= `s` every cycle; counter held at 0.
  - `deb_en_i[n]`=1 and `s` == `gpio_in_o[n]`: counter <= 0.
  - `deb_en_i[n]`=1, `s` != `gpio_in_o[n]`, and `tick`:
    - if counter+1 >= max(`deb_thr_i`,1): `gpio_in_o[n]` <= `s` and counter <= 0;
    - otherwise counter <= counter+1.
    - Counter saturates; the compare is done at DEB_CNT_W+1 bits.
  - A glitch shorter than the threshold resets the counter, and the output does not change.
  - Lowering `deb_thr_i` mid-count commits on the next tick if the count already meets the new threshold.
- **Edge / pending**
  - Rise = `gpio_in_o[n]` changing 0->1; fall = 1->0.
  - `irq_pend_o[n]` is set on the same clock edge that `gpio_in_o[n]` updates, if the matching enable is 1.
  - `irq_clr_i[n]` clears the bit.
  - A set and a clear in the same cycle: set wins.
  - Enables are sampled in the cycle of the change only; enabling later does not retro-set a bit.
- **IRQ**
  - `irq_o` <= |(`irq_pend_o` & `irq_mask_i`), registered.
  - Masking does not clear pending bits.

## Timing
- **Debounce off**
  - Pad change sampled at clock edge E0 (sync1), E1 (sync2).
  - `gpio_in_o` and the pending bit update at E2.
  - `irq_o` updates at E3.
- **Debounce on**
  - `gpio_in_o` updates on the edge ending the `deb_thr_i`-th tick cycle in which `s` differed continuously.
  - Worst case ≈ 2 + `deb_thr_i`×(`psc_div_i`+1) cycles.
- **Clear path:** `irq_clr_i` at edge E clears pending at E; `irq_o` deasserts at E+1 if no other masked pending bits remain.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset with pins high:** hold `pad_in_i`=16'hFFFF through reset with `irq_rise_en_i`=16'hFFFF -> `gpio_in_o`=16'hFFFF by cycle 3 after release, `irq_pend_o`=0 and `irq_o`=0 throughout.
- **No-debounce latency:** `deb_en_i`=0, `irq_rise_en_i[3]`=1, `irq_mask_i[3]`=1, drive pin 3 high at edge E0 -> `gpio_in_o[3]`=1 and `irq_pend_o`=16'h0008 at E2, `irq_o`=1 at E3; pulse `irq_clr_i[3]` -> `irq_pend_o`=0 next edge, `irq_o`=0 one cycle after that.
- **Debounce timing:** `deb_en_i[5]`=1, `psc_div_i`=3, `deb_thr_i`=4, pin 5 steps 0->1 -> `gpio_in_o[5]` rises between 15 and 19 cycles after the pad change; a 10-cycle glitch produces no change and no pending bit.
- **Falling edge, masked:** `irq_fall_en_i[12]`=1, `irq_mask_i[12]`=0, pin 12 goes 1->0 -> `irq_pend_o[12]`=1 and `irq_o`=0; then set `irq_mask_i[12]`=1 -> `irq_o`=1 one cycle later.
- **Set/clear collision:** a pin-0 rising edge reaches `gpio_in_o` in the same cycle `irq_clr_i[0]` pulses -> `irq_pend_o[0]` remains 1.
- **Reset mid-count:** with debounce counter at 2 of 4, assert `rst_n_i`=0 for one cycle -> all outputs 0, counter restarts from 0, warm-up repeats.
